// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the instruction/data memory arbiter.
package mem_arb_pkg;

    localparam int unsigned ARB_ADDR_W = 32;
    localparam int unsigned ARB_DATA_W = 32;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_DATA  = 2'd1,
        ARB_FETCH = 2'd2
    } arb_state_t;

endpackage

// File: rtl/ifetch_buf.sv
// One-entry instruction buffer: remembers the last fetched PC and its word,
// and flags a hit when the current fetch address matches.
module ifetch_buf
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic [ADDR_W-1:0] pc,
    output logic              ihit,
    output logic [DATA_W-1:0] data
);

    logic              ibuf_valid_r;
    logic [ADDR_W-1:0] ibuf_addr_r;
    logic [DATA_W-1:0] ibuf_data_r;

    // Buffer entry register, refilled only on a completed fetch
    always_ff @(posedge clk) begin
        if (!reset) begin
            ibuf_valid_r <= 1'b0;
            ibuf_addr_r  <= {ADDR_W{1'b0}};
            ibuf_data_r  <= {DATA_W{1'b0}};
        end else if (load) begin
            ibuf_valid_r <= 1'b1;
            ibuf_addr_r  <= load_addr;
            ibuf_data_r  <= load_data;
        end else begin
            ibuf_valid_r <= ibuf_valid_r;
            ibuf_addr_r  <= ibuf_addr_r;
            ibuf_data_r  <= ibuf_data_r;
        end
    end

    assign ihit = ibuf_valid_r & (ibuf_addr_r == pc);
    assign data = ibuf_data_r;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data access,
// data first, and stalls the whole pipeline while either access is pending.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pcF,
    output logic [DATA_W-1:0] instrF,
    input  logic              memreadM,
    input  logic              memwriteM,
    input  logic [ADDR_W-1:0] aluoutM,
    input  logic [DATA_W-1:0] writedataM,
    output logic [DATA_W-1:0] readdataM,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t        state_r, state_s;
    logic              mem_req_r, mem_req_s;
    logic              mem_we_r, mem_we_s;
    logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
    logic [DATA_W-1:0] mem_wdata_r, mem_wdata_s;
    logic              ddone_r, ddone_s;
    logic [DATA_W-1:0] dbuf_r, dbuf_s;
    logic              ibuf_load_s;
    logic              ihit_s;
    logic              dreq_s;
    logic              stall_s;

    // The request address register doubles as the buffer tag for the fill
    ifetch_buf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ifetch_buf (
        .clk       (clk),
        .reset     (reset),
        .load      (ibuf_load_s),
        .load_addr (mem_addr_r),
        .load_data (mem_rdata),
        .pc        (pcF),
        .ihit      (ihit_s),
        .data      (instrF)
    );

    assign dreq_s  = memreadM | memwriteM;
    assign stall_s = (dreq_s & ~ddone_r) | ~ihit_s;

    // Next-state, request-register and completion-flag decode
    always_comb begin
        state_s     = state_r;
        mem_req_s   = mem_req_r;
        mem_we_s    = mem_we_r;
        mem_addr_s  = mem_addr_r;
        mem_wdata_s = mem_wdata_r;
        dbuf_s      = dbuf_r;
        ibuf_load_s = 1'b0;
        ddone_s     = stall_s ? ddone_r : 1'b0;

        case (state_r)
            ARB_IDLE: begin
                if (dreq_s && !ddone_r) begin
                    state_s     = ARB_DATA;
                    mem_req_s   = 1'b1;
                    mem_we_s    = memwriteM;
                    mem_addr_s  = aluoutM;
                    mem_wdata_s = writedataM;
                end else if (!ihit_s) begin
                    state_s    = ARB_FETCH;
                    mem_req_s  = 1'b1;
                    mem_we_s   = 1'b0;
                    mem_addr_s = pcF;
                end else begin
                    state_s = ARB_IDLE;
                end
            end
            ARB_DATA: begin
                if (mem_ready) begin
                    state_s   = ARB_IDLE;
                    mem_req_s = 1'b0;
                    mem_we_s  = 1'b0;
                    ddone_s   = 1'b1;
                    if (!mem_we_r) begin
                        dbuf_s = mem_rdata;
                    end else begin
                        dbuf_s = dbuf_r;
                    end
                end else begin
                    state_s = ARB_DATA;
                end
            end
            ARB_FETCH: begin
                if (mem_ready) begin
                    state_s     = ARB_IDLE;
                    mem_req_s   = 1'b0;
                    mem_we_s    = 1'b0;
                    ibuf_load_s = 1'b1;
                end else begin
                    state_s = ARB_FETCH;
                end
            end
            default: begin
                state_s   = ARB_IDLE;
                mem_req_s = 1'b0;
                mem_we_s  = 1'b0;
            end
        endcase
    end

    // State, memory-request and data-return registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= ARB_IDLE;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
            ddone_r     <= 1'b0;
            dbuf_r      <= {DATA_W{1'b0}};
        end else begin
            state_r     <= state_s;
            mem_req_r   <= mem_req_s;
            mem_we_r    <= mem_we_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
            ddone_r     <= ddone_s;
            dbuf_r      <= dbuf_s;
        end
    end

    assign stall     = stall_s;
    assign readdataM = dbuf_r;
    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a scoreboard of expected memory requests is
// served by an inline memory model while pipeline stall lengths are counted.
module tb_mem_arbiter;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waits;
    } req_t;

    logic        clk;
    logic        reset;
    logic [31:0] pcF;
    logic [31:0] instrF;
    logic        memreadM;
    logic        memwriteM;
    logic [31:0] aluoutM;
    logic [31:0] writedataM;
    logic [31:0] readdataM;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    req_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .pcF        (pcF),
        .instrF     (instrF),
        .memreadM   (memreadM),
        .memwriteM  (memwriteM),
        .aluoutM    (aluoutM),
        .writedataM (writedataM),
        .readdataM  (readdataM),
        .stall      (stall),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Serve queued requests and count stall cycles until the pipeline advances
    task automatic run_access(input string tag, input int exp_stalls);
        int   n;
        int   cnt;
        bit   active;
        bit   done;
        req_t r;
        n = 0; cnt = 0; active = 1'b0; done = 1'b0;
        r = '{1'b0, 32'h0, 32'h0, 32'h0, 0};
        for (int i = 0; i < 100 && !done; i++) begin
            mem_ready = 1'b0;
            if (mem_req === 1'b1 && !active) begin
                if (exp_q.size() == 0) begin
                    chk({tag, "_unexpected_req"}, mem_addr, 32'hFFFF_FFFF);
                end else begin
                    r = exp_q.pop_front();
                    chk({tag, "_we"}, 32'(mem_we), 32'(r.we));
                    chk({tag, "_addr"}, mem_addr, r.addr);
                    if (r.we) chk({tag, "_wdata"}, mem_wdata, r.wdata);
                    active = 1'b1;
                    cnt = r.waits;
                end
            end
            if (active) begin
                if (cnt == 0) begin
                    mem_ready = 1'b1;
                    mem_rdata = r.rdata;
                    active = 1'b0;
                end else begin
                    cnt--;
                end
            end
            #1;
            if (stall === 1'b0) done = 1'b1;
            else begin
                n++;
                step();
            end
        end
        chk({tag, "_stall_cycles"}, 32'(n), 32'(exp_stalls));
        chk({tag, "_req_low_at_advance"}, 32'(mem_req), 32'(1'b0));
    endtask

    initial begin
        reset = 1'b0; pcF = 32'h0; memreadM = 1'b0; memwriteM = 1'b0;
        aluoutM = 32'h0; writedataM = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0;

        repeat (3) step();
        #1;
        chk("rst_mem_req", 32'(mem_req), 32'(1'b0));
        chk("rst_mem_we", 32'(mem_we), 32'(1'b0));
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_instr", instrF, 32'h0);
        chk("rst_rdata", readdataM, 32'h0);
        chk("rst_stall", 32'(stall), 32'(1'b1));

        // Fetch miss out of reset, zero wait
        step();
        reset = 1'b1;
        exp_q.push_back('{1'b0, 32'h0, 32'h0, 32'h2008_0005, 0});
        run_access("fetch0", 2);
        chk("fetch0_instr", instrF, 32'h2008_0005);

        // Load with three wait states, fetch hitting
        step();
        memreadM = 1'b1; aluoutM = 32'h40;
        exp_q.push_back('{1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF, 3});
        run_access("load3w", 5);
        chk("load3w_rdata", readdataM, 32'hDEAD_BEEF);

        // Next M instruction is another load: completion flag must have cleared
        step();
        aluoutM = 32'h44;
        exp_q.push_back('{1'b0, 32'h44, 32'h0, 32'hCAFE_F00D, 0});
        run_access("load_b2b", 2);
        chk("load_b2b_rdata", readdataM, 32'hCAFE_F00D);

        // Store and fetch miss together: store first, then fetch
        step();
        memreadM = 1'b0; memwriteM = 1'b1; aluoutM = 32'h80;
        writedataM = 32'h1234_5678; pcF = 32'h10;
        exp_q.push_back('{1'b1, 32'h80, 32'h1234_5678, 32'h0, 0});
        exp_q.push_back('{1'b0, 32'h10, 32'h0, 32'h8C09_0004, 1});
        run_access("st_fetch", 5);
        chk("st_fetch_instr", instrF, 32'h8C09_0004);
        chk("st_fetch_rdata_kept", readdataM, 32'hCAFE_F00D);

        step();
        memwriteM = 1'b0; pcF = 32'h14;
        exp_q.push_back('{1'b0, 32'h14, 32'h0, 32'h0109_5020, 0});
        run_access("fetch14", 2);
        chk("fetch14_instr", instrF, 32'h0109_5020);

        // Held PC must keep hitting with no memory traffic
        for (int i = 0; i < 4; i++) begin
            step();
            #1;
            chk("hold_stall", 32'(stall), 32'(1'b0));
            chk("hold_req", 32'(mem_req), 32'(1'b0));
            chk("hold_instr", instrF, 32'h0109_5020);
        end

        // Spurious ready while idle
        mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        step();
        mem_ready = 1'b0;
        #1;
        chk("spur_instr", instrF, 32'h0109_5020);
        chk("spur_rdata", readdataM, 32'hCAFE_F00D);
        chk("spur_stall", 32'(stall), 32'(1'b0));
        chk("spur_req", 32'(mem_req), 32'(1'b0));
        step();
        #1;
        chk("spur_req_later", 32'(mem_req), 32'(1'b0));

        // Reset during a fetch wait cycle, then a late ready
        step();
        pcF = 32'h18;
        #1;
        chk("rmid_miss_stall", 32'(stall), 32'(1'b1));
        step();
        #1;
        chk("rmid_req_up", 32'(mem_req), 32'(1'b1));
        step();
        reset = 1'b0;
        #1;
        chk("rmid_req_wait", 32'(mem_req), 32'(1'b1));
        step();
        #1;
        chk("rmid_req_dropped", 32'(mem_req), 32'(1'b0));
        chk("rmid_stall_in_rst", 32'(stall), 32'(1'b1));
        reset = 1'b1; mem_ready = 1'b1; mem_rdata = 32'hAAAA_AAAA;
        step();
        mem_ready = 1'b0;
        #1;
        chk("rmid_instr_cleared", instrF, 32'h0);
        chk("rmid_stall_after", 32'(stall), 32'(1'b1));
        exp_q.push_back('{1'b0, 32'h18, 32'h0, 32'h8D0A_0000, 0});
        run_access("refetch", 1);
        chk("refetch_instr", instrF, 32'h8D0A_0000);

        // Load with fetch miss, zero wait: four stall cycles
        step();
        memreadM = 1'b1; aluoutM = 32'h100; pcF = 32'h1C;
        exp_q.push_back('{1'b0, 32'h100, 32'h0, 32'h0BAD_F00D, 0});
        exp_q.push_back('{1'b0, 32'h1C, 32'h0, 32'h3C01_1001, 0});
        run_access("ld_fetch", 4);
        chk("ld_fetch_rdata", readdataM, 32'h0BAD_F00D);
        chk("ld_fetch_instr", instrF, 32'h3C01_1001);

        step();
        memreadM = 1'b0;
        #1;
        chk("end_stall", 32'(stall), 32'(1'b0));
        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one unified, variable-latency, single-port memory between the pipeline's instruction-fetch port (F stage) and data port (M stage). Data accesses take priority, and a one-entry instruction buffer absorbs repeated fetches of the same PC. A single pipeline-wide `stall` is raised while either port's access is outstanding. Sits between the `mips` core and the memory model inside the top-level wrapper.

## Interface
- `ADDR_W`, 32, memory address width
- `DATA_W`, 32, memory data width

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  synchronous, active-low (0 = reset)
- `pcF`  in  ADDR_W  fetch address
- `instrF`  out  DATA_W  fetched instruction, valid when `stall`=0
- `memreadM`  in  1  M-stage load
- `memwriteM`  in  1  M-stage store
- `aluoutM`  in  ADDR_W  data address
- `writedataM`  in  DATA_W  store data
- `readdataM`  out  DATA_W  load data, valid when `stall`=0
- `stall`  out  1  freeze F/D/E/M/W; pipeline advances on cycles with `stall`=0
- `mem_req`  out  1  memory request, held until `mem_ready`
- `mem_we`  out  1  1 = write
- `mem_addr`  out  ADDR_W  request address, stable while `mem_req`
- `mem_wdata`  out  DATA_W  write data, stable while `mem_req`
- `mem_ready`  in  1  one-cycle completion pulse; `mem_rdata` valid same cycle
- `mem_rdata`  in  DATA_W  read data

## Operation
- **Signals:** `dreq` = `memreadM` | `memwriteM`; `ihit` = `ibuf_valid` & (`ibuf_addr` == `pcF`).
- **`ddone`:** set on data completion; cleared on any cycle with `stall`=0, i.e. when M advances.
- **Stall:** `stall` = (`dreq` & ~`ddone`) | ~`ihit`, combinational.
- **Outputs:** `instrF` = `ibuf_data`; `readdataM` = `dbuf_data`. Both are register-driven.
- **FSM states:** `ARB_IDLE`, `ARB_DATA`, `ARB_FETCH`.
  - `ARB_IDLE`: if `dreq` & ~`ddone`, latch `aluoutM`/`writedataM`/`memwriteM` into request registers and go to `ARB_DATA`. Else if ~`ihit`, latch `pcF` and go to `ARB_FETCH`. Else stay.
  - `ARB_DATA`: `mem_req`=1 and `mem_we` = latched write flag. On `mem_ready`: set `ddone`; for reads, `dbuf_data` ← `mem_rdata`; go to `ARB_IDLE`.
  - `ARB_FETCH`: `mem_req`=1, `mem_we`=0. On `mem_ready`: `ibuf_addr` ← latched address, `ibuf_data` ← `mem_rdata`, `ibuf_valid` ← 1; go to `ARB_IDLE`.
- **Priority:** when data and fetch are both pending in `ARB_IDLE`, data wins. The M instruction is older, and fetch cannot starve because the whole pipeline is stalled.
- **Registered request outputs:** `mem_req`/`mem_we`/`mem_addr`/`mem_wdata` are registers, so they cannot glitch. `mem_addr` and `mem_wdata` hold their value when idle.
- **Address sampling:** the request address is sampled once. A `pcF` change during `ARB_FETCH` does not affect the in-flight request; the mismatch simply produces a miss afterwards and a new fetch.
- **Spurious ready:** `mem_ready` in `ARB_IDLE` is ignored.
- **Store data:** stores never modify `ibuf`. Self-modifying code is unsupported.

## Timing
- **Reset** (`reset`=0 at an edge): state `ARB_IDLE`, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `ibuf_valid`=0, `ibuf_data`=0, `dbuf_data`=0, `ddone`=0. Consequently `stall`=1 out of reset (fetch miss).
- **Reset mid-transaction:** the request is abandoned; `mem_req` is 0 after that edge. A late `mem_ready` is ignored.
- **Zero-wait memory** (`mem_ready` in the first `mem_req` cycle):
  - Fetch miss: detect in cycle 0, request in cycle 1, `stall`=0 in cycle 2. That is 2 stall cycles.
  - Load with fetch hit: 2 stall cycles.
  - Load plus fetch miss: 4 stall cycles.
- **Wait states:** each wait cycle of `mem_ready` adds 1 stall cycle.
- **Back-to-back:** `mem_req` is low for at least one cycle between back-to-back transactions (the `ARB_IDLE` decision cycle).
- **Fetch hit with no data request:** `stall`=0 with zero latency.

## Structure
- **Package `mem_arb_pkg`:** `arb_state_t` enum (`ARB_IDLE`, `ARB_DATA`, `ARB_FETCH`) and default width constants.
- **Sub-module `ifetch_buf`:** holds `ibuf_addr`/`ibuf_data`/`ibuf_valid`, with a load port and the `ihit` compare.
- **Remaining logic:** FSM, request registers, `ddone`, and `dbuf` stay in `mem_arbiter`.

## Test plan
- **Reset then fetch:** release `reset`, `pcF`=0x0, memory returns 0x20080005 with zero wait. Expect `mem_req` high cycle 1 with `mem_addr`=0x0 and `mem_we`=0; `stall` falls cycle 2; `instrF`=0x20080005.
- **Load with 3 wait states:** fetch hit, `memreadM`=1, `aluoutM`=0x40, memory returns 0xDEADBEEF. Expect `stall` high for 5 cycles; `readdataM`=0xDEADBEEF on the first `stall`=0 cycle; `ddone` cleared the next cycle.
- **Simultaneous store and fetch miss:** `memwriteM`=1, `aluoutM`=0x80, `writedataM`=0x12345678, `pcF`=0x10 (miss). Expect the first request to be a write to 0x80 with `mem_wdata`=0x12345678, then a read of 0x10; `stall` falls after both complete.
- **Repeated PC (hazard stall):** after `pcF`=0x14 is fetched, hold `pcF`=0x14. Expect no new `mem_req` and `stall`=0 throughout.
- **Reset mid-fetch:** assert `reset`=0 in a `ARB_FETCH` wait cycle. Expect `mem_req`=0 next cycle. A `mem_ready` after release leaves `ibuf_valid`=0 and `stall`=1.
- **Spurious ready:** pulse `mem_ready` in `ARB_IDLE` with `mem_rdata`=0xFFFFFFFF. Expect no change to `instrF`, `readdataM`, or state.
